// File: rtl/dbus_pkg.sv
// -----------------------------------------------------------------------------
// dbus_pkg
// Shared types and constants for the data-bus arbiter:
//   state_t       - arbiter FSM states (IDLE, ACCESS)
//   master_idx_t  - index of a bus master (0 = CPU LSU, 1 = loader/DMA)
//   REGION_*      - address region codes decoded from addr[31:28]
//   region_sel()  - region code -> {uart_sel, dmem_sel}
// -----------------------------------------------------------------------------
package dbus_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   typedef logic master_idx_t;

   localparam logic [3:0] REGION_DMEM = 4'h0;
   localparam logic [3:0] REGION_UART = 4'h8;

   // Returns {uart_hit, dmem_hit}; both zero for an unmapped region.
   function automatic logic [1:0] region_sel(input logic [3:0] region);
      logic [1:0] sel;
      sel[0] = (region == REGION_DMEM);
      sel[1] = (region == REGION_UART);
      return sel;
   endfunction

endpackage

// File: rtl/dbus_rr_arb.sv
// -----------------------------------------------------------------------------
// dbus_rr_arb
// Combinational two-way round-robin pick.
//   req_i        in  2  request vector {m1, m0}
//   last_grant_i in  1  master granted most recently
//   grant_o      out 2  one-hot grant (all zero when nobody requests)
// With both requesting, the master that was not granted last wins.
// -----------------------------------------------------------------------------
module dbus_rr_arb
   import dbus_pkg::*;
(
   input  logic [1:0]  req_i,
   input  master_idx_t last_grant_i,
   output logic [1:0]  grant_o
);

   // Round-robin selection between the two request lines
   always_comb begin
      grant_o = 2'b00;
      case (req_i)
         2'b01:   grant_o = 2'b01;
         2'b10:   grant_o = 2'b10;
         2'b11:   grant_o = (last_grant_i == 1'b1) ? 2'b01 : 2'b10;
         default: grant_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/dbus_arbiter.sv
// -----------------------------------------------------------------------------
// dbus_arbiter
// Shares the data bus (dmem + UART) between m0 (CPU load/store unit) and
// m1 (loader/DMA). One transaction is outstanding at a time; requests are
// arbitrated round-robin in IDLE, the winner's command is latched and driven
// onto the bus for the whole ACCESS phase, and completion is reported to the
// owning master with a one-cycle done pulse plus read data.
//
// Ports (N = 0,1):
//   clk, rst_n                  clock, async active-low reset
//   mN_req/addr/wdata/wr/mask   master command, req held until mN_gnt
//   mN_gnt                      accept pulse (same cycle the request is seen)
//   mN_done/mN_rdata            completion pulse and read data (0 for writes)
//   mN_err                      bus error with done (DBUS_TIMEOUT_EN only)
//   dbus_addr/data_wr/mask/wr   slave command, zero outside ACCESS
//   dmem_sel/uart_sel           region selects (addr[31:28] = 0x0 / 0x8)
//   dbus_data_rd, uart_ready    slave read data, UART completion
//
// Optional feature: define DBUS_TIMEOUT_EN to add the mN_err ports, abort an
// ACCESS after TIMEOUT_CYCLES cycles and flag unmapped addresses as errors.
// -----------------------------------------------------------------------------
module dbus_arbiter
   import dbus_pkg::*;
#(
   parameter int DMEM_LATENCY   = 1,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m0_req,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic        m0_wr,
   input  logic [3:0]  m0_mask,
   output logic        m0_gnt,
   output logic        m0_done,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic        m1_wr,
   input  logic [3:0]  m1_mask,
   output logic        m1_gnt,
   output logic        m1_done,
   output logic [31:0] m1_rdata,
`ifdef DBUS_TIMEOUT_EN
   output logic        m0_err,
   output logic        m1_err,
`endif
   output logic [31:0] dbus_addr,
   output logic [31:0] dbus_data_wr,
   output logic [3:0]  dbus_mask,
   output logic        dbus_wr,
   output logic        dmem_sel,
   output logic        uart_sel,
   input  logic [31:0] dbus_data_rd,
   input  logic        uart_ready
);

   localparam int CNT_MAX = (DMEM_LATENCY > TIMEOUT_CYCLES) ? DMEM_LATENCY : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_SAT       = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] DMEM_DONE_CNT = CNT_W'(DMEM_LATENCY);
`ifdef DBUS_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TIMEOUT_CNT   = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   master_idx_t        last_grant_q, last_grant_d;
   master_idx_t        owner_q, owner_d;
   logic [31:0]        addr_q, addr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic               wr_q, wr_d;
   logic [3:0]         mask_q, mask_d;
   logic [1:0]         done_q, done_d;
   logic [1:0][31:0]   rdata_q, rdata_d;
`ifdef DBUS_TIMEOUT_EN
   logic [1:0]         err_q, err_d;
   logic               cmp_err_s;
`endif

   logic [1:0]         arb_grant_s;
   logic [1:0]         gnt_s;
   logic [1:0]         sel_s;
   logic               access_s;
   logic               complete_s;
   logic [31:0]        cmp_rdata_s;

   dbus_rr_arb u_rr_arb (
      .req_i        ({m1_req, m0_req}),
      .last_grant_i (last_grant_q),
      .grant_o      (arb_grant_s)
   );

   // Grants are only issued from IDLE and are suppressed while reset is held,
   // so gnt drops the moment rst_n falls.
   assign gnt_s    = arb_grant_s & {2{(state_q == IDLE) & rst_n}};
   assign access_s = (state_q == ACCESS);
   assign sel_s    = region_sel(addr_q[31:28]);

   // Next-state logic: arbitration, command latch, wait-state count, completion
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wr_d         = wr_q;
      mask_d       = mask_q;
      done_d       = 2'b00;
      rdata_d      = rdata_q;
      complete_s   = 1'b0;
      cmp_rdata_s  = 32'h0;
`ifdef DBUS_TIMEOUT_EN
      err_d        = err_q;
      cmp_err_s    = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (gnt_s != 2'b00) begin
               state_d      = ACCESS;
               cnt_d        = {CNT_W{1'b0}};
               owner_d      = gnt_s[1];
               last_grant_d = gnt_s[1];
               if (gnt_s[1]) begin
                  addr_d  = m1_addr;
                  wdata_d = m1_wdata;
                  wr_d    = m1_wr;
                  mask_d  = m1_mask;
               end else begin
                  addr_d  = m0_addr;
                  wdata_d = m0_wdata;
                  wr_d    = m0_wr;
                  mask_d  = m0_mask;
               end
            end else begin
               state_d = IDLE;
            end
         end
         ACCESS: begin
            if (sel_s[0] && (cnt_q == DMEM_DONE_CNT)) begin
               complete_s  = 1'b1;
               cmp_rdata_s = wr_q ? 32'h0 : dbus_data_rd;
            end else if (sel_s[1] && uart_ready) begin
               complete_s  = 1'b1;
               cmp_rdata_s = wr_q ? 32'h0 : dbus_data_rd;
            end else if (sel_s == 2'b00) begin
               // Unmapped region: nothing will answer, finish right away.
               complete_s  = 1'b1;
`ifdef DBUS_TIMEOUT_EN
               cmp_err_s   = 1'b1;
`endif
`ifdef DBUS_TIMEOUT_EN
            end else if (cnt_q == TIMEOUT_CNT) begin
               complete_s  = 1'b1;
               cmp_err_s   = 1'b1;
`endif
            end else begin
               cnt_d = (cnt_q == CNT_SAT) ? cnt_q : (cnt_q + CNT_W'(1'b1));
            end

            if (complete_s) begin
               state_d          = IDLE;
               done_d[owner_q]  = 1'b1;
               rdata_d[owner_q] = cmp_rdata_s;
`ifdef DBUS_TIMEOUT_EN
               err_d[owner_q]   = cmp_err_s;
`endif
            end else begin
               state_d = ACCESS;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= {CNT_W{1'b0}};
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         addr_q       <= 32'h0;
         wdata_q      <= 32'h0;
         wr_q         <= 1'b0;
         mask_q       <= 4'h0;
         done_q       <= 2'b00;
         rdata_q      <= {2{32'h0}};
`ifdef DBUS_TIMEOUT_EN
         err_q        <= 2'b00;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wr_q         <= wr_d;
         mask_q       <= mask_d;
         done_q       <= done_d;
         rdata_q      <= rdata_d;
`ifdef DBUS_TIMEOUT_EN
         err_q        <= err_d;
`endif
      end
   end

   assign m0_gnt       = gnt_s[0];
   assign m1_gnt       = gnt_s[1];
   assign m0_done      = done_q[0];
   assign m1_done      = done_q[1];
   assign m0_rdata     = rdata_q[0];
   assign m1_rdata     = rdata_q[1];
`ifdef DBUS_TIMEOUT_EN
   assign m0_err       = err_q[0];
   assign m1_err       = err_q[1];
`endif
   assign dbus_addr    = access_s ? addr_q  : 32'h0;
   assign dbus_data_wr = access_s ? wdata_q : 32'h0;
   assign dbus_mask    = access_s ? mask_q  : 4'h0;
   assign dbus_wr      = access_s & wr_q;
   assign dmem_sel     = access_s & sel_s[0];
   assign uart_sel     = access_s & sel_s[1];

endmodule

// File: tb/tb_dbus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dbus_arbiter
// Self-checking bench for dbus_arbiter. A table of single transactions is run
// through one task; every grant pushes the expected completion (master, cycle,
// rdata, err) onto a scoreboard queue that is popped when a done pulse shows
// up. Hand-written sequences cover round-robin, reset mid-transaction and,
// with DBUS_TIMEOUT_EN, the access timeout.
// -----------------------------------------------------------------------------
module tb_dbus_arbiter;

   localparam int DL = 1;
   localparam int TO = 16;
`ifdef DBUS_TIMEOUT_EN
   localparam logic UNMAP_ERR = 1'b1;
`else
   localparam logic UNMAP_ERR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_req, m0_wr, m1_req, m1_wr;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [3:0]  m0_mask, m1_mask;
   logic        m0_gnt, m0_done, m1_gnt, m1_done;
   logic [31:0] m0_rdata, m1_rdata;
`ifdef DBUS_TIMEOUT_EN
   logic        m0_err, m1_err;
`endif
   logic [31:0] dbus_addr, dbus_data_wr, dbus_data_rd;
   logic [3:0]  dbus_mask;
   logic        dbus_wr, dmem_sel, uart_sel, uart_ready;

   typedef struct { int lat; logic [31:0] rdata; logic err; } exp_t;
   typedef struct { int m; int due; logic [31:0] rdata; logic err; } sb_t;
   typedef struct {
      int          m;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        wr;
      logic [3:0]  mask;
      logic [31:0] rd;
      int          uwait;
      int          lat;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   uart_wait = 0;
   exp_t exp_rec [2];
   sb_t  sb [$];
   int   gnt_log [$];
   vec_t vecs [7];

   dbus_arbiter #(.DMEM_LATENCY(DL), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wr(m0_wr),
      .m0_mask(m0_mask), .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wr(m1_wr),
      .m1_mask(m1_mask), .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
`ifdef DBUS_TIMEOUT_EN
      .m0_err(m0_err), .m1_err(m1_err),
`endif
      .dbus_addr(dbus_addr), .dbus_data_wr(dbus_data_wr), .dbus_mask(dbus_mask),
      .dbus_wr(dbus_wr), .dmem_sel(dmem_sel), .uart_sel(uart_sel),
      .dbus_data_rd(dbus_data_rd), .uart_ready(uart_ready)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h cycle=%0d", name, act, req, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // UART model: ready after uart_wait cycles of uart_sel.
   initial begin
      int idx;
      idx = 0;
      uart_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (uart_sel) begin
            uart_ready = (idx == uart_wait);
            idx++;
         end else begin
            uart_ready = 1'b0;
            idx = 0;
         end
      end
   end

   // Monitor: grants push expectations, done pulses pop and compare.
   initial begin : monitor
      int  dm;
      sb_t e;
      forever begin
         @(negedge clk);
         if (m0_gnt || m1_gnt) begin
            check("single_gnt", {31'h0, m0_gnt & m1_gnt}, 32'h0);
            dm = m0_gnt ? 0 : 1;
            gnt_log.push_back(dm);
            sb.push_back('{dm, cyc + exp_rec[dm].lat, exp_rec[dm].rdata, exp_rec[dm].err});
         end
         if (m0_done || m1_done) begin
            check("single_done", {31'h0, m0_done & m1_done}, 32'h0);
            check("sel_at_done", {30'h0, dmem_sel, uart_sel}, 32'h0);
            dm = m0_done ? 0 : 1;
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done master=%0d actual=done required=no_done cycle=%0d", dm, cyc);
            end else begin
               e = sb.pop_front();
               check("done_master", 32'(dm), 32'(e.m));
               check("done_cycle", 32'(cyc), 32'(e.due));
               check("done_rdata", (dm == 0) ? m0_rdata : m1_rdata, e.rdata);
`ifdef DBUS_TIMEOUT_EN
               check("done_err", {31'h0, (dm == 0) ? m0_err : m1_err}, {31'h0, e.err});
`endif
            end
         end
      end
   end

   task automatic drive(input int m, input logic req, input vec_t v);
      if (m == 0) begin
         m0_req = req; m0_addr = v.addr; m0_wdata = v.wdata; m0_wr = v.wr; m0_mask = v.mask;
      end else begin
         m1_req = req; m1_addr = v.addr; m1_wdata = v.wdata; m1_wr = v.wr; m1_mask = v.mask;
      end
   endtask

   task automatic wait_idle(input string tag);
      for (int k = 0; k < 100; k++) begin
         @(posedge clk);
         if (sb.size() == 0) break;
      end
      check({tag, "_drain"}, 32'(sb.size()), 32'h0);
      #2;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      bit got;
      got = 1'b0;
      dbus_data_rd = v.rd;
      uart_wait    = v.uwait;
      exp_rec[v.m] = '{v.lat, v.exp_rdata, v.exp_err};
      drive(v.m, 1'b1, v);
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         got = (v.m == 0) ? m0_gnt : m1_gnt;
      end
      check({tag, "_gnt"}, {31'h0, got}, 32'h1);
      @(posedge clk);
      #2;
      drive(v.m, 1'b0, v);
      if (got) begin
         @(negedge clk);
         check({tag, "_addr"}, dbus_addr, v.addr);
         check({tag, "_wdata"}, dbus_data_wr, v.wdata);
         check({tag, "_mask_wr"}, {27'h0, dbus_mask, dbus_wr}, {27'h0, v.mask, v.wr});
         check({tag, "_sel"}, {30'h0, dmem_sel, uart_sel},
               {30'h0, v.addr[31:28] == 4'h0, v.addr[31:28] == 4'h8});
      end
      wait_idle(tag);
   endtask

   initial begin
      vec_t va, vb;
      rst_n = 1'b0;
      dbus_data_rd = 32'h0;
      va = '{0, 32'h0000_0010, 32'h0, 1'b0, 4'hF, 32'h0, 0, 2 + DL, 32'h0, 1'b0};
      drive(0, 1'b0, va);
      drive(1, 1'b0, va);
      exp_rec[0] = '{0, 32'h0, 1'b0};
      exp_rec[1] = '{0, 32'h0, 1'b0};

      //        m  addr          wdata         wr    mask   rd            uw  lat      rdata         err
      vecs[0] = '{0, 32'h0000_0010, 32'h0,        1'b0, 4'hF,  32'hDEAD_BEEF, 0, 2 + DL, 32'hDEAD_BEEF, 1'b0};
      vecs[1] = '{1, 32'h0000_0100, 32'h0,        1'b0, 4'hF,  32'h1234_5678, 0, 2 + DL, 32'h1234_5678, 1'b0};
      vecs[2] = '{0, 32'h0000_0020, 32'hAABB_CCDD, 1'b1, 4'hF,  32'h5555_5555, 0, 2 + DL, 32'h0,         1'b0};
      vecs[3] = '{1, 32'h8000_0000, 32'h0000_0041, 1'b1, 4'h1,  32'h0000_0077, 3, 5,      32'h0,         1'b0};
      vecs[4] = '{0, 32'h8000_0004, 32'h0,        1'b0, 4'hF,  32'h0000_00A5, 0, 2,      32'h0000_00A5, 1'b0};
      vecs[5] = '{0, 32'h4000_0000, 32'h0,        1'b0, 4'hF,  32'h6666_6666, 0, 2,      32'h0,         UNMAP_ERR};
      vecs[6] = '{1, 32'h8000_0008, 32'h0,        1'b0, 4'h3,  32'hCAFE_F00D, 1, 3,      32'hCAFE_F00D, 1'b0};

      // Reset state, including a request held during reset.
      repeat (2) @(posedge clk);
      #2;
      m0_req = 1'b1;
      @(negedge clk);
      check("rst_outputs", {dbus_addr[27:0], dbus_mask}, 32'h0);
      check("rst_ctrl", {25'h0, m0_gnt, m1_gnt, m0_done, m1_done, dmem_sel, uart_sel, dbus_wr}, 32'h0);
      check("rst_rdata", m0_rdata | m1_rdata | dbus_data_wr, 32'h0);
      @(posedge clk);
      #2;
      m0_req = 1'b0;
      rst_n  = 1'b1;

      // Round-robin: both held from reset, expect m0, m1, m0.
      dbus_data_rd = 32'h0BAD_F00D;
      exp_rec[0] = '{2 + DL, 32'h0BAD_F00D, 1'b0};
      exp_rec[1] = '{2 + DL, 32'h0BAD_F00D, 1'b0};
      vb = va;
      vb.addr = 32'h0000_0040;
      gnt_log.delete();
      drive(0, 1'b1, va);
      drive(1, 1'b1, vb);
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         if (gnt_log.size() >= 3) break;
      end
      #2;
      drive(0, 1'b0, va);
      drive(1, 1'b0, vb);
      check("rr_count", 32'(gnt_log.size()), 32'h3);
      if (gnt_log.size() >= 3) begin
         check("rr_order", {29'h0, gnt_log[0][0], gnt_log[1][0], gnt_log[2][0]}, 32'h2);
      end
      wait_idle("rr");

      for (int i = 0; i < 7; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

`ifdef DBUS_TIMEOUT_EN
      va = '{0, 32'h8000_0020, 32'h0, 1'b0, 4'hF, 32'h0000_0099, 1000, TO + 1, 32'h0, 1'b1};
      run_vec(va, "timeout");
      run_vec(vecs[1], "after_timeout");
`endif

      // Reset in the middle of an m0 UART access that would never finish.
      va = '{0, 32'h8000_0010, 32'h0, 1'b0, 4'hF, 32'h0, 1000, 1000, 32'h0, 1'b0};
      uart_wait = 1000;
      exp_rec[0] = '{1000, 32'h0, 1'b0};
      drive(0, 1'b1, va);
      for (int k = 0; k < 20 && !m0_gnt; k++) @(negedge clk);
      @(posedge clk);
      #2;
      drive(0, 1'b0, va);
      @(posedge clk);
      #2;
      va = '{0, 32'h0000_0030, 32'h0, 1'b0, 4'hF, 32'h1357_2468, 0, 2 + DL, 32'h1357_2468, 1'b0};
      vb = va;
      vb.addr = 32'h0000_0034;
      dbus_data_rd = 32'h1357_2468;
      uart_wait = 0;
      exp_rec[0] = '{2 + DL, 32'h1357_2468, 1'b0};
      exp_rec[1] = '{2 + DL, 32'h1357_2468, 1'b0};
      check("pre_rst_busy", {31'h0, uart_sel}, 32'h1);
      drive(0, 1'b1, va);
      drive(1, 1'b1, vb);
      rst_n = 1'b0;
      #1;
      check("mid_rst_clear", {28'h0, uart_sel, m0_gnt, m1_gnt, m0_done | m1_done}, 32'h0);
      sb.delete();
      repeat (2) @(posedge clk);
      #2;
      gnt_log.delete();
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         if (gnt_log.size() >= 1) break;
      end
      #2;
      drive(0, 1'b0, va);
      drive(1, 1'b0, vb);
      check("rst_first_gnt", (gnt_log.size() > 0) ? 32'(gnt_log[0]) : 32'h99, 32'h0);
      wait_idle("post_rst");
      repeat (5) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
